// File: rtl/spi_cmd_ctrl.sv
// SPI command sequencer: parses chip-select frames into pixel, register, status and swap
// commands, drives the frame-buffer and register ports, and queues a one-byte MISO reply.
module spi_cmd_ctrl #(
  parameter int ADDR_W   = 11,
  parameter int FB_DEPTH = 2048,
  parameter int REG_AW   = 4
) (
  input  logic              clk_sb,
  input  logic              reset_n,
  input  logic              cs_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              tx_busy,
  output logic              tx_req,
  output logic [7:0]        tx_data,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_wdata,
  output logic              reg_we,
  output logic [REG_AW-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  input  logic [7:0]        reg_rdata,
  output logic              frame_swap,
  output logic              cmd_err
);

  // state    | meaning
  // IDLE     | waiting for a chip-select falling edge
  // CMD      | waiting for the command byte
  // PIX_AH   | waiting for pixel address high byte
  // PIX_AL   | waiting for pixel address low byte
  // PIX_DATA | streaming pixel bytes into the frame buffer
  // REG_A    | waiting for register address (write)
  // REG_D    | waiting for register data
  // RD_A     | waiting for register address (read)
  // DONE     | command complete; extra bytes are an error
  // DISCARD  | bad command or address; ignore rest of frame
  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_PIX_AH, S_PIX_AL, S_PIX_DATA,
    S_REG_A, S_REG_D, S_RD_A, S_DONE, S_DISCARD
  } state_t;

  state_t            state_q, state_d;
  logic              cs_q;
  logic [7:0]        addr_hi_q, addr_hi_d;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
  logic [7:0]        resp_q, resp_d;
  logic              resp_pend_q, resp_pend_d;
  logic              swap_pend_q, swap_pend_d;
  logic              rd_cap_q, rd_cap_d;
  logic              tx_req_q, tx_req_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              fb_we_q, fb_we_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [7:0]        fb_wdata_q, fb_wdata_d;
  logic              reg_we_q, reg_we_d;
  logic [REG_AW-1:0] reg_addr_q, reg_addr_d;
  logic [7:0]        reg_wdata_q, reg_wdata_d;
  logic              frame_swap_q, frame_swap_d;
  logic              cmd_err_q, cmd_err_d;
  logic              err_set, err_clr, cs_rise;
  logic [15:0]       full_addr;

  always_comb begin
    state_d      = state_q;
    addr_hi_d    = addr_hi_q;
    pix_addr_d   = pix_addr_q;
    resp_d       = resp_q;
    resp_pend_d  = resp_pend_q;
    swap_pend_d  = swap_pend_q;
    rd_cap_d     = 1'b0;
    tx_req_d     = 1'b0;
    tx_data_d    = tx_data_q;
    fb_we_d      = 1'b0;
    fb_addr_d    = fb_addr_q;
    fb_wdata_d   = fb_wdata_q;
    reg_we_d     = 1'b0;
    reg_addr_d   = reg_addr_q;
    reg_wdata_d  = reg_wdata_q;
    frame_swap_d = 1'b0;
    err_set      = 1'b0;
    err_clr      = 1'b0;
    cs_rise      = !cs_q && cs_n;
    full_addr    = {addr_hi_q, rx_data};

    // reg_rdata is valid the cycle after reg_addr was latched by a read
    if (rd_cap_q) begin
      resp_d      = reg_rdata;
      resp_pend_d = 1'b1;
    end

    if (cs_rise) begin
      if (resp_pend_d) begin
        if (tx_busy) begin
          err_set = 1'b1;
        end else begin
          tx_req_d  = 1'b1;
          tx_data_d = resp_d;
        end
        resp_pend_d = 1'b0;
      end
      frame_swap_d = swap_pend_q;
      swap_pend_d  = 1'b0;
    end

    if (cs_n) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (cs_q) state_d = S_CMD;
        S_CMD: if (rx_valid) begin
          case (rx_data)
            8'h01: state_d = S_PIX_AH;
            8'h02: state_d = S_REG_A;
            8'h03: state_d = S_RD_A;
            8'h04: begin
              resp_d      = {cmd_err_q, tx_busy, 6'b0};
              resp_pend_d = 1'b1;
              err_clr     = 1'b1;
              state_d     = S_DONE;
            end
            8'h05: begin
              swap_pend_d = 1'b1;
              state_d     = S_DONE;
            end
            default: begin
              err_set = 1'b1;
              state_d = S_DISCARD;
            end
          endcase
        end
        S_PIX_AH: if (rx_valid) begin
          addr_hi_d = rx_data;
          state_d   = S_PIX_AL;
        end
        S_PIX_AL: if (rx_valid) begin
          if (int'(full_addr) >= FB_DEPTH) begin
            err_set = 1'b1;
            state_d = S_DISCARD;
          end else begin
            pix_addr_d = full_addr[ADDR_W-1:0];
            state_d    = S_PIX_DATA;
          end
        end
        S_PIX_DATA: if (rx_valid) begin
          fb_we_d    = 1'b1;
          fb_addr_d  = pix_addr_q;
          fb_wdata_d = rx_data;
          pix_addr_d = (pix_addr_q == ADDR_W'(FB_DEPTH - 1)) ? '0 : pix_addr_q + 1'b1;
        end
        S_REG_A: if (rx_valid) begin
          reg_addr_d = rx_data[REG_AW-1:0];
          state_d    = S_REG_D;
        end
        S_REG_D: if (rx_valid) begin
          reg_we_d    = 1'b1;
          reg_wdata_d = rx_data;
          state_d     = S_DONE;
        end
        S_RD_A: if (rx_valid) begin
          reg_addr_d = rx_data[REG_AW-1:0];
          rd_cap_d   = 1'b1;
          state_d    = S_DONE;
        end
        S_DONE: if (rx_valid) err_set = 1'b1;
        default: ;
      endcase
    end

    // a new error outranks the status-read clear
    cmd_err_d = err_set | (cmd_err_q & ~err_clr);
  end

  always_ff @(posedge clk_sb or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cs_q         <= 1'b1;
      addr_hi_q    <= '0;
      pix_addr_q   <= '0;
      resp_q       <= '0;
      resp_pend_q  <= 1'b0;
      swap_pend_q  <= 1'b0;
      rd_cap_q     <= 1'b0;
      tx_req_q     <= 1'b0;
      tx_data_q    <= '0;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_wdata_q   <= '0;
      reg_we_q     <= 1'b0;
      reg_addr_q   <= '0;
      reg_wdata_q  <= '0;
      frame_swap_q <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cs_q         <= cs_n;
      addr_hi_q    <= addr_hi_d;
      pix_addr_q   <= pix_addr_d;
      resp_q       <= resp_d;
      resp_pend_q  <= resp_pend_d;
      swap_pend_q  <= swap_pend_d;
      rd_cap_q     <= rd_cap_d;
      tx_req_q     <= tx_req_d;
      tx_data_q    <= tx_data_d;
      fb_we_q      <= fb_we_d;
      fb_addr_q    <= fb_addr_d;
      fb_wdata_q   <= fb_wdata_d;
      reg_we_q     <= reg_we_d;
      reg_addr_q   <= reg_addr_d;
      reg_wdata_q  <= reg_wdata_d;
      frame_swap_q <= frame_swap_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

  assign tx_req     = tx_req_q;
  assign tx_data    = tx_data_q;
  assign fb_we      = fb_we_q;
  assign fb_addr    = fb_addr_q;
  assign fb_wdata   = fb_wdata_q;
  assign reg_we     = reg_we_q;
  assign reg_addr   = reg_addr_q;
  assign reg_wdata  = reg_wdata_q;
  assign frame_swap = frame_swap_q;
  assign cmd_err    = cmd_err_q;

endmodule
